// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable 50% duty clock divider with shadowed divide values
// Ports: clk_in rising-edge clock; rst_n async active-low reset; ch_en per-channel run enable;
//   cfg_we/cfg_ch/cfg_div write divide value D (each phase lasts D+1 cycles) into a channel's shadow;
//   clk_out registered divided clocks; tick one-cycle pulse aligned with each clk_out rise.
// Optional: define CLKDIV_SYNC_EN to add sync_pulse, which restarts all running channels in phase.
module clk_div_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W = 8,
  parameter int DEF_DIV = 0,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_pulse,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  typedef enum logic [1:0] {STOP, LOW, HIGH} state_t;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t state_q, state_d;
    logic [DIV_W-1:0] shadow_q, shadow_d, active_q, active_d, cnt_q, cnt_d;
    logic stop_q, stop_d, clk_q, clk_d, tick_q, tick_d;
    always_comb begin
      // out-of-range cfg_ch values match no channel and are dropped
      shadow_d = (cfg_we && cfg_ch == CH_W'(i)) ? cfg_div : shadow_q;
      active_d = active_q;
      state_d = state_q;
      cnt_d = cnt_q + 1'b1;
      if (state_q == STOP) begin
        cnt_d = '0;
        if (ch_en[i]) begin
          state_d = LOW;
          active_d = shadow_d;
        end
      end else if (state_q == LOW && !ch_en[i]) begin
        state_d = STOP;
        cnt_d = '0;
      end else if (cnt_q == active_q) begin
        cnt_d = '0;
        if (state_q == LOW)
          state_d = HIGH;
        else if (stop_q || !ch_en[i])
          state_d = STOP;
        else begin
          state_d = LOW;
          active_d = shadow_d;
        end
      end
`ifdef CLKDIV_SYNC_EN
      if (sync_pulse && state_q != STOP) begin
        state_d = ch_en[i] ? LOW : STOP;
        cnt_d = '0;
        active_d = shadow_d;
      end
`endif
      // remembers a disable seen mid-high so the high pulse completes before stopping
      stop_d = state_d == HIGH && (stop_q || !ch_en[i]);
      clk_d = state_d == HIGH;
      tick_d = state_d == HIGH && state_q != HIGH;
    end
    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= STOP;
        shadow_q <= DIV_W'(DEF_DIV);
        active_q <= DIV_W'(DEF_DIV);
        cnt_q <= '0;
        stop_q <= 1'b0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        state_q <= state_d;
        shadow_q <= shadow_d;
        active_q <= active_d;
        cnt_q <= cnt_d;
        stop_q <= stop_d;
        clk_q <= clk_d;
        tick_q <= tick_d;
      end
    end
    assign clk_out[i] = clk_q;
    assign tick[i] = tick_q;
  end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: randomized and directed checks of clk_div_gen against a phase-countdown model
module tb_clk_div_gen;
  localparam int NCH = 5;
  localparam int DW = 4;
  localparam int DEF = 2;
  localparam int CHW = 3;
  logic clk_in, rst_n, cfg_we, sync_pulse;
  logic [NCH-1:0] ch_en, clk_out, tick, exp_clk, exp_tick;
  logic [CHW-1:0] cfg_ch;
  logic [DW-1:0] cfg_div;
  int n_chk, n_err;
  int sh[NCH], act[NCH], left[NCH];
  bit run[NCH], high[NCH], pend[NCH];
  clk_div_gen #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(DEF)) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .ch_en(ch_en),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
`ifdef CLKDIV_SYNC_EN
    .sync_pulse(sync_pulse),
`endif
    .clk_out(clk_out),
    .tick(tick)
  );
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      sh[c] = DEF;
      act[c] = DEF;
      left[c] = 0;
      run[c] = 0;
      high[c] = 0;
      pend[c] = 0;
    end
    exp_clk = '0;
    exp_tick = '0;
  endtask
  // left = cycles remaining in the current phase; a phase of divide D lasts D+1 cycles
  task automatic model_step();
    if (cfg_we && cfg_ch < NCH) sh[cfg_ch] = int'(cfg_div);
    for (int c = 0; c < NCH; c++) begin
      bit tk;
      tk = 0;
      if (!run[c]) begin
        if (ch_en[c]) begin
          run[c] = 1;
          high[c] = 0;
          pend[c] = 0;
          act[c] = sh[c];
          left[c] = act[c] + 1;
        end
      end else if (sync_pulse) begin
        pend[c] = 0;
        high[c] = 0;
        if (ch_en[c]) begin
          act[c] = sh[c];
          left[c] = act[c] + 1;
        end else run[c] = 0;
      end else if (!high[c] && !ch_en[c]) begin
        run[c] = 0;
      end else begin
        left[c]--;
        if (high[c] && !ch_en[c]) pend[c] = 1;
        if (left[c] == 0) begin
          if (!high[c]) begin
            high[c] = 1;
            left[c] = act[c] + 1;
            tk = 1;
          end else begin
            high[c] = 0;
            if (pend[c]) run[c] = 0;
            else begin
              act[c] = sh[c];
              left[c] = act[c] + 1;
            end
            pend[c] = 0;
          end
        end
      end
      exp_clk[c] = run[c] && high[c];
      exp_tick[c] = tk;
    end
  endtask
  task automatic cyc();
    @(posedge clk_in);
    model_step();
    #1;
    chk("clk_out", 32'(clk_out), 32'(exp_clk));
    chk("tick", 32'(tick), 32'(exp_tick));
  endtask
  task automatic wr(input int c, input int d);
    cfg_we = 1'b1;
    cfg_ch = CHW'(c);
    cfg_div = DW'(d);
    cyc();
    cfg_we = 1'b0;
  endtask
  task automatic gap(input int c, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[c] && n < 200);
  endtask
  initial begin
    int n, h, t, t0, t1;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    ch_en = '0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    sync_pulse = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_tick", 32'(tick), 0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) cyc();
    // D=0 on ch0: divide by 2, tick every other cycle
    wr(0, 0);
    ch_en[0] = 1'b1;
    repeat (4) cyc();
    n = 0;
    repeat (20) begin
      cyc();
      n += int'(tick[0]);
    end
    chk("d0_ticks", n, 10);
    // write during HIGH: current high phase keeps D=3, the following low uses D=1
    wr(1, 3);
    ch_en[1] = 1'b1;
    gap(1, n);
    gap(1, n);
    chk("d3_gap", n, 8);
    wr(1, 1);
    gap(1, n);
    chk("wr_gap", n + 1, 6);
    gap(1, n);
    chk("d1_gap", n, 4);
    // disable on second high cycle: two more high cycles, then silent
    wr(2, 3);
    ch_en[2] = 1'b1;
    gap(2, n);
    cyc();
    ch_en[2] = 1'b0;
    h = 0;
    t = 0;
    repeat (12) begin
      cyc();
      h += int'(clk_out[2]);
      t += int'(tick[2]);
    end
    chk("stop_high", h, 2);
    chk("stop_tick", t, 0);
    // out-of-range channel writes change nothing
    for (int cc = NCH; cc < 8; cc++) wr(cc, 9);
    gap(0, n);
    gap(0, n);
    chk("oor_gap0", n, 2);
    gap(1, n);
    gap(1, n);
    chk("oor_gap1", n, 4);
    // maximum divide value
    wr(3, 15);
    ch_en[3] = 1'b1;
    gap(3, n);
    gap(3, n);
    chk("max_gap", n, 32);
    // asynchronous reset in the middle of a high phase
    gap(3, n);
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_tick", 32'(tick), 0);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    cyc();
    gap(1, n);
    gap(1, n);
    chk("def_gap", n, 2 * (DEF + 1));
`ifdef CLKDIV_SYNC_EN
    ch_en = '0;
    repeat (40) cyc();
    wr(0, 2);
    wr(1, 5);
    ch_en[1:0] = 2'b11;
    repeat (17) cyc();
    sync_pulse = 1'b1;
    cyc();
    sync_pulse = 1'b0;
    chk("sync_low", 32'(clk_out[1:0]), 0);
    t0 = 0;
    t1 = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (tick[0] && t0 == 0) t0 = k;
      if (tick[1] && t1 == 0) t1 = k;
    end
    chk("sync_rise0", t0, 3);
    chk("sync_rise1", t1, 6);
`endif
    // randomized enables, writes (including ignored channels) and sync pulses
    repeat (500) begin
      if ($urandom_range(0, 9) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        cfg_ch = CHW'($urandom_range(0, 7));
        cfg_div = ($urandom_range(0, 9) == 0) ? DW'(15) : DW'($urandom_range(0, 4));
      end
`ifdef CLKDIV_SYNC_EN
      sync_pulse = $urandom_range(0, 29) == 0;
`endif
      cyc();
      cfg_we = 1'b0;
      sync_pulse = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 8, width of each channel's half-period divide value.
REQ-003 SHALL have parameter DEF_DIV, default 0, reset divide value loaded into every channel.
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ch_en  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-007 SHALL have port cfg_we  input  1  one-cycle divide-value write strobe.
REQ-008 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  channel index for the write.
REQ-009 SHALL have port cfg_div  input  DIV_W  divide value D for the write.
REQ-010 SHALL have port clk_out  output  NUM_CH  registered divided square waves.
REQ-011 SHALL have port tick  output  NUM_CH  one-cycle pulse per clk_out rising edge.

Function
REQ-012 SHALL keep per channel a shadow divide register, an active divide register, a DIV_W-bit counter cnt and a state in {STOP, LOW, HIGH}.
REQ-013 SHALL, on cfg_we with cfg_ch < NUM_CH, write cfg_div into that channel's shadow register; cfg_ch >= NUM_CH SHALL be ignored.
REQ-014 SHALL, in LOW or HIGH, increment cnt each cycle and, when cnt == active, clear cnt and change phase (LOW->HIGH, HIGH->LOW); each phase lasts active+1 cycles, period 2*(D+1) cycles.
REQ-015 SHALL drive clk_out high exactly in HIGH and low in STOP and LOW, from a register (no combinational path to the output).
REQ-016 SHALL copy shadow into active only on HIGH->LOW transitions and on STOP->LOW; a write never alters the period in progress.
REQ-017 SHALL, when cfg_we targets a channel in the same cycle it loads active, load the newly written cfg_div (write-through).
REQ-018 SHALL move STOP->LOW with cnt = 0 on the cycle after ch_en is sampled high.
REQ-019 SHALL, when ch_en is sampled low in LOW, go to STOP next cycle; when sampled low in HIGH, finish the high phase, then go to STOP instead of LOW (no shortened high pulse).
REQ-020 SHALL assert tick for exactly the first cycle clk_out is high in each period, aligned with clk_out.
REQ-021 SHALL treat D = 0 as divide-by-2 and D = 2^DIV_W-1 as the maximum period without counter overflow.

Reset
REQ-022 SHALL, while rst_n is low, force asynchronously: clk_out = 0, tick = 0, cnt = 0, state = STOP, shadow = active = DEF_DIV on all channels.
REQ-023 SHALL, on reset assertion mid-HIGH, drop clk_out to 0 immediately; after release, a channel with ch_en high SHALL restart from LOW with cnt = 0 after one cycle.

Configuration
REQ-024 SHALL support macro CLKDIV_SYNC_EN; when defined, add input port sync_pulse (1 bit) forcing every channel in LOW or HIGH to LOW with cnt = 0 and active reloaded from shadow on the next cycle, no tick generated, so all running channels become phase-aligned.
REQ-025 SHALL give ch_en low priority over sync_pulse (channel goes to STOP); sync_pulse SHALL not affect channels in STOP.
REQ-026 SHALL, when CLKDIV_SYNC_EN is undefined, omit sync_pulse and its logic entirely; all other behaviour is unchanged.

Verification
REQ-027 SHALL cover: ch0 D=0, ch_en[0]=1 -> clk_out[0] period 2 cycles, 50% duty, tick[0] every 2nd cycle.
REQ-028 SHALL cover: ch1 D=3 running, write D=1 during HIGH -> current period completes at 8 cycles, following periods 4 cycles.
REQ-029 SHALL cover: ch2 D=3, ch_en[2] dropped on 2nd HIGH cycle -> clk_out[2] stays high 2 more cycles (4 total), then 0, state STOP, no further ticks.
REQ-030 SHALL cover: rst_n pulled low mid-HIGH -> clk_out = 0 and tick = 0 without a clock edge; shadow reads back DEF_DIV behaviour after release.
REQ-031 SHALL cover: cfg_we with cfg_ch = NUM_CH -> no channel period changes.
REQ-032 SHALL cover (CLKDIV_SYNC_EN): ch0 D=2, ch1 D=5 free-running, sync_pulse one cycle -> both enter LOW with cnt = 0 together and rise together 3 cycles later (ch0) and 6 cycles later (ch1).
